// File: rtl/aud_pkg.sv
// Shared types and defaults for the I2S ADC receive path.
package aud_pkg;

    localparam int AUD_DATA_W = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ALIGN,
        S_SHIFT,
        S_HOLD
    } state_e;

    typedef enum logic {
        CH_LEFT,
        CH_RIGHT
    } chan_e;

endpackage

// File: rtl/i2s_adc_receiver_if.sv
// Stereo sample hand-off bundle between the I2S receiver and its consumer.
interface i2s_adc_receiver_if #(
    parameter int DATA_W = aud_pkg::AUD_DATA_W
);
    logic [DATA_W-1:0] left;
    logic [DATA_W-1:0] right;
    logic              valid;
    logic              ready;
    logic              overrun;

    modport master (
        output left,
        output right,
        output valid,
        output overrun,
        input  ready
    );

    modport slave (
        input  left,
        input  right,
        input  valid,
        input  overrun,
        output ready
    );
endinterface

// File: rtl/aud_sync.sv
// Multi-flop synchronizer for one codec input, with a single-cycle rise pulse.
module aud_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q,
    output logic o_rise
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;

    always_comb begin
        sync_d = (sync_q << 1) | SYNC_STAGES'(i_d);
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign o_q    = sync_q[SYNC_STAGES-1];
    assign o_rise = sync_q[SYNC_STAGES-1] & ~prev_q;
endmodule

// File: rtl/i2s_adc_receiver.sv
// I2S slave receiver: deserializes codec ADC data (codec is bit-clock master)
// and publishes complete left/right pairs through a valid/ready hand-off.
module i2s_adc_receiver
    import aud_pkg::*;
#(
    parameter int DATA_W      = AUD_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_enable,
    input  logic              i_aud_bclk,
    input  logic              i_aud_adclrck,
    input  logic              i_aud_adcdat,
    output logic [DATA_W-1:0] o_left,
    output logic [DATA_W-1:0] o_right,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_overrun
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    logic bclk_rise;
    logic lrc_s;
    logic dat_s;
    logic unused_bclk_lvl;
    logic unused_lrc_rise;
    logic unused_dat_rise;

    aud_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bclk (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_aud_bclk),
        .o_q     (unused_bclk_lvl),
        .o_rise  (bclk_rise)
    );

    aud_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lrc (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_aud_adclrck),
        .o_q     (lrc_s),
        .o_rise  (unused_lrc_rise)
    );

    aud_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dat (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_aud_adcdat),
        .o_q     (dat_s),
        .o_rise  (unused_dat_rise)
    );

    state_e            state_q, state_d;
    chan_e             ch_q, ch_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] left_shadow_q, left_shadow_d;
    logic              left_vld_q, left_vld_d;
    logic              prev_lrc_q, prev_lrc_d;
    logic [DATA_W-1:0] left_q, left_d;
    logic [DATA_W-1:0] right_q, right_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;

    logic [DATA_W-1:0] word_nxt;
    logic              ch_start;
    logic              handshake;
    logic              publish;

    // Every rise shifts the serial bit in; the word is only kept where the FSM says so.
    assign word_nxt  = {shift_q[DATA_W-2:0], dat_s};
    assign ch_start  = bclk_rise & (lrc_s != prev_lrc_q);
    assign handshake = valid_q & i_ready;

    always_comb begin
        state_d       = state_q;
        ch_d          = ch_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        left_shadow_d = left_shadow_q;
        left_vld_d    = left_vld_q;
        prev_lrc_d    = prev_lrc_q;
        left_d        = left_q;
        right_d       = right_q;
        valid_d       = valid_q;
        overrun_d     = overrun_q;
        publish       = 1'b0;

        if (bclk_rise) begin
            prev_lrc_d = lrc_s;
        end

        if (!i_enable) begin
            state_d    = S_IDLE;
            bit_cnt_d  = '0;
            left_vld_d = 1'b0;
            valid_d    = 1'b0;
            overrun_d  = 1'b0;
        end else begin
            if (handshake) begin
                valid_d = 1'b0;
            end

            unique case (state_q)
                S_IDLE: begin
                    state_d = S_ALIGN;
                end

                S_ALIGN: begin
                    if (ch_start && !lrc_s) begin
                        state_d   = S_SHIFT;
                        ch_d      = CH_LEFT;
                        bit_cnt_d = '0;
                    end
                end

                S_SHIFT: begin
                    if (ch_start) begin
                        // Short word: drop it; a truncated left leaves no pair to complete.
                        bit_cnt_d = '0;
                        if (lrc_s) begin
                            left_vld_d = 1'b0;
                            state_d    = S_ALIGN;
                        end else begin
                            ch_d = CH_LEFT;
                        end
                    end else if (bclk_rise) begin
                        shift_d = word_nxt;
                        if (bit_cnt_q == CNT_LAST) begin
                            bit_cnt_d = '0;
                            state_d   = S_HOLD;
                            if (ch_q == CH_LEFT) begin
                                left_shadow_d = word_nxt;
                                left_vld_d    = 1'b1;
                            end else begin
                                publish    = left_vld_q;
                                left_vld_d = 1'b0;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                end

                S_HOLD: begin
                    if (ch_start) begin
                        state_d   = S_SHIFT;
                        ch_d      = lrc_s ? CH_RIGHT : CH_LEFT;
                        bit_cnt_d = '0;
                    end
                end
            endcase

            if (publish) begin
                if (!valid_q || handshake) begin
                    left_d  = left_shadow_q;
                    right_d = word_nxt;
                    valid_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= S_IDLE;
            ch_q          <= CH_LEFT;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            left_shadow_q <= '0;
            left_vld_q    <= 1'b0;
            prev_lrc_q    <= 1'b0;
            left_q        <= '0;
            right_q       <= '0;
            valid_q       <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ch_q          <= ch_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            left_shadow_q <= left_shadow_d;
            left_vld_q    <= left_vld_d;
            prev_lrc_q    <= prev_lrc_d;
            left_q        <= left_d;
            right_q       <= right_d;
            valid_q       <= valid_d;
            overrun_q     <= overrun_d;
        end
    end

    assign o_left    = left_q;
    assign o_right   = right_q;
    assign o_valid   = valid_q;
    assign o_overrun = overrun_q;
endmodule
